// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state, master IDs and cycle-type constants for the SDRAM Wishbone arbiter
package sdram_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_e;
  localparam logic [1:0] M_VID  = 2'd0;
  localparam logic [1:0] M_SND  = 2'd1;
  localparam logic [1:0] M_CPU  = 2'd2;
  localparam logic [1:0] M_NONE = 2'd3;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
endpackage

// File: rtl/sdram_arb_pick.sv
// sdram_arb_pick: fixed-priority pick (m0 > m1 > m2) with CPU starvation override
// Ports: req - per-master request, starve - CPU starvation threshold reached, owner - chosen master (M_NONE if none)
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic       starve,
  output logic [1:0] owner
);
  always_comb
    owner = (starve && req[2]) ? M_CPU :
            req[0]             ? M_VID :
            req[1]             ? M_SND :
            req[2]             ? M_CPU : M_NONE;
endmodule

// File: rtl/sdram_wb_arbiter.sv
// sdram_wb_arbiter: three-master Wishbone arbiter in front of the SDRAM controller slave port
// Ports: wb_clk/wb_rst - clock and async active-high reset; mN_* - master N bus (N=0 video, 1 sound, 2 CPU);
//        m_dat_o - read data broadcast; s_* - slave port; gnt - current owner (3 = none); busy - a master is granted
module sdram_wb_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADR_W      = 24,
  parameter int STARVE_MAX = 4
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [31:0]      m0_dat_i,
  input  logic [3:0]       m0_sel,
  input  logic [2:0]       m0_cti,
  input  logic             m0_we,
  input  logic             m0_stb,
  input  logic             m0_cyc,
  output logic             m0_ack,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [31:0]      m1_dat_i,
  input  logic [3:0]       m1_sel,
  input  logic [2:0]       m1_cti,
  input  logic             m1_we,
  input  logic             m1_stb,
  input  logic             m1_cyc,
  output logic             m1_ack,
  input  logic [ADR_W-1:0] m2_adr,
  input  logic [31:0]      m2_dat_i,
  input  logic [3:0]       m2_sel,
  input  logic [2:0]       m2_cti,
  input  logic             m2_we,
  input  logic             m2_stb,
  input  logic             m2_cyc,
  output logic             m2_ack,
  output logic [31:0]      m_dat_o,
  output logic [ADR_W-1:0] s_adr,
  output logic [31:0]      s_dat_i,
  output logic [3:0]       s_sel,
  output logic [2:0]       s_cti,
  output logic             s_we,
  output logic             s_stb,
  output logic             s_cyc,
  input  logic [31:0]      s_dat_o,
  input  logic             s_ack,
  output logic [1:0]       gnt,
  output logic             busy
);
  localparam int BW = ADR_W + 32 + 4 + 3 + 3;
  arb_state_e state_q, state_d;
  logic [1:0] owner_q, owner_d, pick_owner;
  logic [3:0] starve_q, starve_d;
  logic [2:0] req;
  logic [BW-1:0] bus0, bus1, bus2, own_bus, s_bus;
  logic own;
  assign req  = {m2_cyc & m2_stb, m1_cyc & m1_stb, m0_cyc & m0_stb};
  // cyc sits in bit 0 so the release test can read it straight off the owner's bus
  assign bus0 = {m0_adr, m0_dat_i, m0_sel, m0_cti, m0_we, m0_stb, m0_cyc};
  assign bus1 = {m1_adr, m1_dat_i, m1_sel, m1_cti, m1_we, m1_stb, m1_cyc};
  assign bus2 = {m2_adr, m2_dat_i, m2_sel, m2_cti, m2_we, m2_stb, m2_cyc};
  assign own_bus = owner_q == M_VID ? bus0 : owner_q == M_SND ? bus1 : bus2;
  sdram_arb_pick u_pick (
    .req    (req),
    .starve (starve_q >= 4'(STARVE_MAX)),
    .owner  (pick_owner)
  );
  always_ff @(posedge wb_clk or posedge wb_rst)
    if (wb_rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= M_NONE;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    if (state_q == ARB_IDLE) begin
      if (|req) begin
        state_d  = ARB_OWN;
        owner_d  = pick_owner;
        // only DMA grants that bypass a waiting CPU count toward starvation
        starve_d = pick_owner == M_CPU ? 4'd0 :
                   (req[2] && starve_q != 4'hf) ? starve_q + 4'd1 : starve_q;
      end
    end else if (!own_bus[0]) begin
      state_d = ARB_IDLE;
      owner_d = M_NONE;
    end
  end
  always_comb begin
    own     = state_q == ARB_OWN;
    s_bus   = own ? own_bus : '0;
    m0_ack  = s_ack & own & (owner_q == M_VID);
    m1_ack  = s_ack & own & (owner_q == M_SND);
    m2_ack  = s_ack & own & (owner_q == M_CPU);
    gnt     = own ? owner_q : M_NONE;
    busy    = own;
    m_dat_o = s_dat_o;
  end
  assign {s_adr, s_dat_i, s_sel, s_cti, s_we, s_stb, s_cyc} = s_bus;
endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// tb_sdram_wb_arbiter: directed plus randomized check of the arbiter against a behavioural model
module tb_sdram_wb_arbiter;
  logic        wb_clk = 1'b0, wb_rst = 1'b1;
  logic [23:0] adr [3];
  logic [31:0] dat [3];
  logic [3:0]  sel [3];
  logic [2:0]  cti [3];
  logic        we [3], stb [3], cyc [3];
  logic        m0_ack, m1_ack, m2_ack;
  logic [31:0] m_dat_o, s_dat_i, s_dat_o;
  logic [23:0] s_adr;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic        s_we, s_stb, s_cyc, s_ack, busy;
  logic [1:0]  gnt;
  int n_cmp = 0, n_err = 0;
  int m_owner = 3, m_starve = 0, prev_g = 3;
  int glog [$];
  always #5 wb_clk = ~wb_clk;
  sdram_wb_arbiter dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m0_adr(adr[0]), .m0_dat_i(dat[0]), .m0_sel(sel[0]), .m0_cti(cti[0]), .m0_we(we[0]), .m0_stb(stb[0]), .m0_cyc(cyc[0]), .m0_ack(m0_ack),
    .m1_adr(adr[1]), .m1_dat_i(dat[1]), .m1_sel(sel[1]), .m1_cti(cti[1]), .m1_we(we[1]), .m1_stb(stb[1]), .m1_cyc(cyc[1]), .m1_ack(m1_ack),
    .m2_adr(adr[2]), .m2_dat_i(dat[2]), .m2_sel(sel[2]), .m2_cti(cti[2]), .m2_we(we[2]), .m2_stb(stb[2]), .m2_cyc(cyc[2]), .m2_ack(m2_ack),
    .m_dat_o(m_dat_o), .s_adr(s_adr), .s_dat_i(s_dat_i), .s_sel(s_sel), .s_cti(s_cti), .s_we(s_we),
    .s_stb(s_stb), .s_cyc(s_cyc), .s_dat_o(s_dat_o), .s_ack(s_ack), .gnt(gnt), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outputs();
    bit b = m_owner != 3;
    int o = b ? m_owner : 0;
    chk("gnt", 64'(gnt), 64'(m_owner));
    chk("busy", 64'(busy), 64'(b));
    chk("s_cyc", 64'(s_cyc), b ? 64'(cyc[o]) : 64'd0);
    chk("s_stb", 64'(s_stb), b ? 64'(stb[o]) : 64'd0);
    chk("s_we", 64'(s_we), b ? 64'(we[o]) : 64'd0);
    chk("s_adr", 64'(s_adr), b ? 64'(adr[o]) : 64'd0);
    chk("s_dat_i", 64'(s_dat_i), b ? 64'(dat[o]) : 64'd0);
    chk("s_sel", 64'(s_sel), b ? 64'(sel[o]) : 64'd0);
    chk("s_cti", 64'(s_cti), b ? 64'(cti[o]) : 64'd0);
    chk("ack", 64'({m2_ack, m1_ack, m0_ack}), (b && s_ack) ? 64'(1 << o) : 64'd0);
    chk("m_dat_o", 64'(m_dat_o), 64'(s_dat_o));
    chk("starve_cnt", 64'(dut.starve_q), 64'(m_starve));
    if (gnt != 2'd3 && prev_g == 3) glog.push_back(int'(gnt));
    prev_g = int'(gnt);
  endtask
  task automatic model_update();
    bit [2:0] req;
    int o;
    if (wb_rst) begin
      m_owner = 3;
      m_starve = 0;
      return;
    end
    if (m_owner == 3) begin
      for (int n = 0; n < 3; n++) req[n] = cyc[n] & stb[n];
      if (req == 0) return;
      o = (m_starve >= 4 && req[2]) ? 2 : req[0] ? 0 : req[1] ? 1 : 2;
      if (o == 2) m_starve = 0;
      else if (req[2] && m_starve < 15) m_starve++;
      m_owner = o;
    end else if (!cyc[m_owner]) m_owner = 3;
  endtask
  task automatic tick();
    #1 check_outputs();
    @(posedge wb_clk);
    model_update();
    @(negedge wb_clk);
  endtask
  task automatic req_set(input int n, input bit v);
    cyc[n] = v;
    stb[n] = v;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int n = 0; n < 3; n++) begin
      adr[n] = 24'(n * 24'h10); dat[n] = 32'hA0 + 32'(n); sel[n] = 4'hf;
      cti[n] = 3'b000; we[n] = 1'b0; req_set(n, 1'b0);
    end
    s_ack = 1'b0; s_dat_o = 32'h1234_5678;
    @(negedge wb_clk);
    tick(); tick();
    wb_rst = 1'b0;
    // CPU alone
    req_set(2, 1); adr[2] = 24'h000100;
    tick();
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; req_set(2, 0);
    tick(); tick();
    // simultaneous video and CPU
    req_set(0, 1); req_set(2, 1);
    tick(); tick();
    req_set(0, 0);
    tick(); tick(); tick();
    req_set(2, 0);
    tick(); tick();
    // CPU starvation under a continuously re-requesting video master
    glog.delete();
    req_set(2, 1);
    for (int i = 0; i < 10; i++) begin
      req_set(0, i % 2 == 0);
      tick();
    end
    req_set(0, 0); req_set(2, 0);
    tick(); tick();
    chk("starve_seq_len", 64'(glog.size()), 64'd5);
    for (int i = 0; i < 5 && i < glog.size(); i++)
      chk("starve_seq", 64'(glog[i]), i == 4 ? 64'd2 : 64'd0);
    chk("starve_end", 64'(dut.starve_q), 64'd0);
    // sound burst with a video request arriving mid-burst
    req_set(1, 1); cti[1] = 3'b010;
    tick();
    s_ack = 1'b1; req_set(0, 1);
    tick();
    cti[1] = 3'b111;
    tick();
    s_ack = 1'b0; req_set(1, 0); cti[1] = 3'b000;
    tick(); tick();
    req_set(0, 0);
    tick(); tick();
    // asynchronous reset while the CPU owns the slave
    req_set(2, 1);
    tick(); tick();
    s_ack = 1'b1; req_set(0, 1);
    #2 wb_rst = 1'b1;
    #1;
    chk("rst_s_cyc", 64'(s_cyc), 64'd0);
    chk("rst_s_stb", 64'(s_stb), 64'd0);
    chk("rst_m2_ack", 64'(m2_ack), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd3);
    chk("rst_busy", 64'(busy), 64'd0);
    m_owner = 3; m_starve = 0;
    tick();
    wb_rst = 1'b0; req_set(2, 0); s_ack = 1'b0;
    tick();
    chk("post_rst_gnt", 64'(gnt), 64'd0);
    req_set(0, 0);
    tick(); tick();
    // stray slave ack while idle
    s_ack = 1'b1;
    tick(); tick();
    s_ack = 1'b0;
    // randomized traffic
    for (int t = 0; t < 2000; t++) begin
      for (int n = 0; n < 3; n++) begin
        if (cyc[n]) cyc[n] = $urandom_range(3) != 0;
        else cyc[n] = $urandom_range(2) == 0;
        stb[n] = cyc[n] && $urandom_range(3) != 0;
        adr[n] = 24'($urandom); dat[n] = $urandom; sel[n] = 4'($urandom);
        cti[n] = 3'($urandom); we[n] = 1'($urandom);
      end
      s_ack = $urandom_range(2) == 0;
      s_dat_o = $urandom;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sdram_wb_arbiter.md
# sdram_wb_arbiter

Three-master Wishbone arbiter in the `wb_clk` domain that shares the single SDRAM controller slave port between video DMA (m0), sound DMA (m1) and CPU (m2). It has fixed priority m0 > m1 > m2 with a CPU starvation guard. Once a master is granted, it owns the slave for its whole `cyc` period, including 2-beat bursts (`cti`=010). It sits between the chipset/CPU bus masters and the SDRAM controller's `wb_*` port.

## Interface
- `ADR_W`, 24: address width, forwarded unchanged.
- `STARVE_MAX`, 4: number of consecutive DMA grants while m2 is requesting, after which m2 wins the next arbitration. Range 1..15.

Ports:
- `wb_clk`  in  1  chipset clock; all state on rising edge.
- `wb_rst`  in  1  asynchronous, active-high reset.
- `mN_adr`  in  ADR_W  master N address (N=0,1,2).
- `mN_dat_i`  in  32  master N write data.
- `mN_sel`  in  4  master N byte selects.
- `mN_cti`  in  3  master N cycle type.
- `mN_we`  in  1  master N write enable.
- `mN_stb`, `mN_cyc`  in  1  master N strobe/cycle.
- `mN_ack`  out  1  master N acknowledge.
- `m_dat_o`  out  32  read data broadcast to all masters (= `s_dat_o`).
- `s_adr`, `s_dat_i`, `s_sel`, `s_cti`, `s_we`, `s_stb`, `s_cyc`  out  matching widths  to SDRAM slave.
- `s_dat_o`  in  32  slave read data.
- `s_ack`  in  1  slave acknowledge.
- `gnt`  out  2  current owner: 0/1/2, or 3 = none.
- `busy`  out  1  1 while any master is granted.

## Operation
- State machine `{IDLE, OWN}` plus registered `owner[1:0]`.
- **IDLE**: `req[N] = mN_cyc & mN_stb`.
  - If any `req` is set: go to OWN with owner = pick(req, starve).
  - pick: if `starve_cnt >= STARVE_MAX` and `req[2]`, choose m2; otherwise choose the lowest-index requester.
- **OWN**: the slave outputs are a combinational mux of the owner's signals.
  - `mN_ack = s_ack & (owner==N) & OWN`.
  - Non-owners see `ack` = 0.
- **OWN -> IDLE** when the owner's `cyc`=0 at a clock edge. Owner `stb` low with `cyc` high keeps the grant; this covers burst beats and back-to-back accesses inside one cycle.
- In IDLE, all `s_*` control outputs are 0. `s_adr`, `s_dat_i`, `s_sel` and `s_cti` drive 0.
- `starve_cnt` (4 bit, saturating):
  - increments on every grant to m0 or m1 made while `req[2]`=1;
  - clears on a grant to m2;
  - holds otherwise.
- `gnt` = owner in OWN, 3 in IDLE. `busy` = (state==OWN).
- Reset, asynchronous, valid mid-transfer: state=IDLE, `owner`=3, `starve_cnt`=0. Consequently `s_cyc`=`s_stb`=0, all `mN_ack`=0, `gnt`=3, `busy`=0.
- The slave may still complete an aborted access internally. Its `s_ack`, if it arrives in IDLE, is dropped.

## Timing
- **Arbitration latency**: a request sampled at edge E gives a grant at edge E. `s_cyc` and `s_stb` are high in the cycle following E.
- **Release**: owner `cyc` low at edge R returns the arbiter to IDLE at edge R. The earliest next grant is edge R+1, so there is at least one idle cycle between owners. The slave therefore always sees `cyc` drop between masters.
- **Simultaneous requests**: resolved in the same single cycle by pick. A request that appears during OWN waits, with no queueing beyond its held `cyc`/`stb`.
- **Ack path**: combinational from `s_ack` to `mN_ack`, with no added latency. The controller's registered 2-beat burst ack passes through unchanged.
- **Owner abandonment**: if the owner drops `cyc` in the same cycle as `s_ack`, the ack is still delivered to that owner (combinational), then the arbiter releases.

## Structure
- Package `sdram_arb_pkg` holds:
  - state enum `{ARB_IDLE, ARB_OWN}`;
  - master IDs `M_VID=0`, `M_SND=1`, `M_CPU=2`, `M_NONE=3`;
  - CTI constants `CTI_CLASSIC=3'b000`, `CTI_INCR=3'b010`, `CTI_END=3'b111`.
- Sub-module `sdram_arb_pick`: combinational; inputs `req[2:0]`, `starve`; output `owner[1:0]`.
- Top level contains the state register, the counter and the output muxes.

## Test plan
- m2 read only, `adr`=0x000100: grant at first edge, `gnt`=2, `s_adr`=0x000100; `s_ack` is routed to `m2_ack` only; `gnt`=3 one edge after `m2_cyc` falls.
- m0 and m2 request in the same cycle: `gnt`=0. m2 is granted only after m0 drops `cyc`, with one idle cycle between (`s_cyc` low for exactly one cycle).
- m0 continuously re-requests and m2 is held with STARVE_MAX=4: grant sequence 0,0,0,0,2 and `starve_cnt` returns to 0.
- m1 `cti`=010 burst with 2 acks on consecutive cycles while m0 raises a request mid-burst: m1 keeps the grant across both acks; m0 is granted after release.
- `wb_rst` asserted while m2 is owner with `s_stb` high: `s_cyc`, `s_stb` and `m2_ack` go to 0 immediately (asynchronously), `gnt`=3. After release, a pending m0 is granted at the first edge.
- Stray `s_ack` pulse in IDLE: all `mN_ack` stay 0.
